// File: rtl/riscv_pkg.sv
// Shared types for the instruction fetch unit: FIFO entry layout and fetch state.
package riscv_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pc;
    logic        err;
  } ifu_entry_t;

  typedef enum logic {
    RUN,
    HALT
  } ifu_state_t;

endpackage

// File: rtl/riscv_fifo.sv
// Synchronous FIFO with registered head, flush and occupancy count.
// Flush has priority over push and pop in the same cycle.
module riscv_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_ifu_prefetch.sv
// Instruction prefetch: pipelined Wishbone reads feeding a FIFO towards decode,
// with stale-response discard after redirects and in-band bus error reporting.
module riscv_ifu_prefetch
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [29:0] RESET_PC        = 30'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        pc_valid_i,
  input  logic [29:0] pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [29:0] pc_o,
  output logic        err_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  input  logic [31:0] wb_data_i,
  output logic [29:0] wb_addr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  ifu_state_t      state_q, state_d;
  logic            active_q;
  logic [29:0]     fetch_pc_q, fetch_pc_d;
  logic [29:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   credit_used;
  logic            fifo_full, fifo_empty;
  logic            issue, resp, keep, pop;
  ifu_entry_t      push_entry, head;

  // Stale reads never land in the FIFO, so they do not consume credit.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q} - {1'b0, discard_q};

  assign wb_stb_o = active_q && (state_q == RUN)
                 && (outstanding_q < CntW'(MAX_OUTSTANDING))
                 && (credit_used < (CntW + 1)'(DEPTH));
  assign wb_cyc_o  = wb_stb_o || (outstanding_q != '0);
  assign wb_addr_o = fetch_pc_q;
  assign wb_data_o = '0;
  assign wb_sel_o  = 4'hF;
  assign wb_we_o   = 1'b0;

  assign issue = wb_stb_o && !wb_stall_i;
  assign resp  = wb_ack_i || wb_err_i;
  assign keep  = resp && (discard_q == '0) && (state_q == RUN) && !pc_valid_i;
  assign pop   = valid_o && ready_i;

  assign push_entry = '{instr: wb_data_i, pc: resp_pc_q, err: wb_err_i};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CntW'(issue) - CntW'(resp);
    discard_d     = discard_q;
    if (resp && (discard_q != '0)) discard_d = discard_q - CntW'(1);
    if (issue) fetch_pc_d = fetch_pc_q + 30'd1;
    if (keep) begin
      resp_pc_d = resp_pc_q + 30'd1;
      if (wb_err_i) state_d = HALT;
    end
    // Everything still in flight after this edge belongs to the old stream.
    if (pc_valid_i) begin
      fetch_pc_d = pc_i;
      resp_pc_d  = pc_i;
      discard_d  = outstanding_d;
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= RUN;
      active_q      <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  riscv_fifo #(
    .WIDTH($bits(ifu_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .flush_i(pc_valid_i),
    .push_i (keep),
    .data_i (push_entry),
    .pop_i  (pop),
    .data_o (head),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign valid_o = !fifo_empty;
  assign instr_o = head.instr;
  assign pc_o    = head.pc;
  assign err_o   = valid_o && head.err;

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(keep && fifo_full && !pop));
  end

endmodule

// File: tb/tb_riscv_ifu_prefetch.sv
// Bench for riscv_ifu_prefetch: Wishbone slave model with variable latency and a
// stream-order reference model checked on every accepted instruction.
module tb_riscv_ifu_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [29:0] RPC   = 30'h0;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        pc_valid_i = 1'b0;
  logic [29:0] pc_i = '0;
  logic        ready_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic [31:0] wb_data_i = '0;
  logic        valid_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] instr_o, wb_data_o;
  logic [29:0] pc_o, wb_addr_o;
  logic [3:0]  wb_sel_o;

  riscv_ifu_prefetch #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RPC)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pc_valid_i(pc_valid_i), .pc_i(pc_i),
    .ready_i(ready_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .err_o(err_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i),
    .wb_data_i(wb_data_i), .wb_addr_o(wb_addr_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int err_mode = 0;
  int pops = 0;
  int win_hits = 0;
  logic [29:0] win_lo = '0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endfunction

  function automatic logic [31:0] word_of(logic [29:0] a);
    return {~a[1:0], a};
  endfunction

  function automatic logic is_err(logic [29:0] a);
    if (err_mode == 1) return a == 30'd7;
    if (err_mode == 2) return (a % 30'd29) == 30'd11;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Wishbone slave: in-order responses, each due `lat` cycles after its issue.
  typedef struct {
    logic [29:0] addr;
    int          due;
  } req_t;
  req_t q[$];
  req_t slv_r;

  always @(negedge clk) begin
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    wb_data_i = '0;
    if (reset_i) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        slv_r = q.pop_front();
        if (is_err(slv_r.addr)) wb_err_i = 1'b1;
        else wb_ack_i = 1'b1;
        wb_data_i = word_of(slv_r.addr);
      end
      if (wb_stb_o && !wb_stall_i) begin
        q.push_back('{addr: wb_addr_o, due: cyc + lat});
        if ((wb_addr_o - win_lo) < 30'd16) win_hits++;
      end
    end
  end

  // Reference model: accepted instructions form the sequence target, target+1, ...
  // after every redirect or reset, and stop after an error entry.
  logic [29:0] exp_pc = RPC;
  bit          halted_exp = 1'b0;

  always @(negedge clk) begin
    if (reset_i) begin
      exp_pc     = RPC;
      halted_exp = 1'b0;
    end else if (pc_valid_i) begin
      exp_pc     = pc_i;
      halted_exp = 1'b0;
    end else if (halted_exp) begin
      chk("halt_quiet", valid_o, 1'b0);
    end else if (valid_o && ready_i) begin
      chk("pop_pc", pc_o, exp_pc);
      chk("pop_err", err_o, is_err(exp_pc));
      if (!is_err(exp_pc)) chk("pop_instr", instr_o, word_of(exp_pc));
      else halted_exp = 1'b1;
      exp_pc = exp_pc + 30'd1;
      pops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [29:0] a);
    pc_valid_i = 1'b1;
    pc_i       = a;
    step();
    pc_valid_i = 1'b0;
  endtask

  initial begin
    bit          ok;
    logic [29:0] a0;
    logic [29:0] tgt;

    repeat (3) step();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_addr", wb_addr_o, RPC);
    chk("tie_sel", wb_sel_o, 4'hF);
    chk("tie_we", wb_we_o, 1'b0);
    chk("tie_data", wb_data_o, 32'h0);

    // Release and zero-wait streaming.
    ready_i = 1'b1;
    reset_i = 1'b0;
    chk("stb_before_edge", wb_stb_o, 1'b0);
    step();
    chk("stb_first_edge", wb_stb_o, 1'b1);
    chk("addr_first", wb_addr_o, 30'd0);
    step();
    chk("valid_cycle2", valid_o, 1'b0);
    step();
    chk("valid_cycle3", valid_o, 1'b1);
    chk("pc_cycle3", pc_o, 30'd0);
    step();
    chk("pc_cycle4", pc_o, 30'd1);
    step();
    chk("pc_cycle5", pc_o, 30'd2);
    repeat (8) step();

    // Decode stalls: credit limits issues to the FIFO depth.
    win_lo   = 30'h40;
    win_hits = 0;
    ready_i  = 1'b0;
    redirect(30'h40);
    repeat (12) step();
    chk("full_issues", win_hits, DEPTH);
    chk("full_stb", wb_stb_o, 1'b0);
    chk("full_cyc", wb_cyc_o, 1'b0);
    chk("full_head", pc_o, 30'h40);
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("drain_no_gap", valid_o, 1'b1);
    end

    // Three-cycle slave, redirect with two reads in flight.
    lat = 3;
    repeat (8) step();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("two_inflight", ok, 1'b1);
    redirect(30'h100);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("lat3_seen", ok, 1'b1);
    chk("lat3_pc", pc_o, 30'h100);
    chk("lat3_instr", instr_o, word_of(30'h100));

    // Redirect latency on a zero-wait bus, coinciding with ack and pop.
    lat = 1;
    repeat (10) step();
    redirect(30'h200);
    chk("flush_valid", valid_o, 1'b0);
    chk("redir_addr", wb_addr_o, 30'h200);
    chk("redir_stb", wb_stb_o, 1'b1);
    step();
    chk("redir_n2_valid", valid_o, 1'b0);
    step();
    chk("redir_n3_valid", valid_o, 1'b1);
    chk("redir_n3_pc", pc_o, 30'h200);
    repeat (4) step();

    // Bus stall holds the address.
    wb_stall_i = 1'b1;
    a0 = wb_addr_o;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", wb_addr_o, a0);
      chk("stall_stb", wb_stb_o, 1'b1);
    end
    wb_stall_i = 1'b0;
    repeat (10) step();

    // PC wrap-around.
    redirect(30'h3FFFFFFE);
    repeat (8) step();

    // Bus error halts fetching until the next redirect.
    err_mode = 1;
    redirect(30'd4);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid_o && pc_o == 30'd7) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("err_seen", ok, 1'b1);
    chk("err_flag", err_o, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halt_stb", wb_stb_o, 1'b0);
    end
    err_mode = 0;
    redirect(30'h20);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("restart_seen", ok, 1'b1);
    chk("restart_pc", pc_o, 30'h20);
    repeat (6) step();

    // Asynchronous reset mid-burst.
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_err", err_o, 1'b0);
    chk("arst_stb", wb_stb_o, 1'b0);
    chk("arst_cyc", wb_cyc_o, 1'b0);
    chk("arst_addr", wb_addr_o, RPC);
    step();
    reset_i = 1'b0;
    repeat (3) step();
    chk("rerun_valid", valid_o, 1'b1);
    chk("rerun_pc", pc_o, RPC);

    // Randomized traffic: ready, stalls, redirects, latencies and sparse errors.
    err_mode = 2;
    redirect(30'h300);
    for (int ph = 0; ph < 2; ph++) begin
      lat = (ph == 0) ? 2 : 1;
      for (int i = 0; i < 300; i++) begin
        ready_i    = ($urandom % 4) != 0;
        wb_stall_i = ($urandom % 8) == 0;
        if (($urandom % 4) == 0) tgt = 30'h3FFFFFFC + 30'($urandom % 3);
        else tgt = 30'($urandom);
        pc_valid_i = ($urandom % 25) == 0;
        pc_i       = tgt;
        step();
      end
    end
    pc_valid_i = 1'b0;
    wb_stall_i = 1'b0;
    repeat (10) step();
    chk("progress", pops > 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
